// File: rtl/shared_divider_arbiter_if.sv
// Client-side bundle for shared_divider_arbiter: per-channel request/operand buses
// and the shared result/status signals returned to every channel.
interface shared_divider_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int N_CH  = 2,
    parameter int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic [N_CH-1:0]       req;
    logic [N_CH*WIDTH-1:0] dividend_bus;
    logic [N_CH*WIDTH-1:0] divisor_bus;
    logic [N_CH-1:0]       ack;
    logic [WIDTH-1:0]      quotient;
    logic [WIDTH-1:0]      remainder;
    logic                  div_zero;
    logic                  busy;
    logic [ID_W-1:0]       grant_id;

    modport master (
        output req, dividend_bus, divisor_bus,
        input  ack, quotient, remainder, div_zero, busy, grant_id
    );

    modport slave (
        input  req, dividend_bus, divisor_bus,
        output ack, quotient, remainder, div_zero, busy, grant_id
    );
endinterface

// File: rtl/shared_divider_arbiter.sv
// N-channel round-robin arbitrated restoring divider, one quotient bit per cycle.
// Define DIV_ROUND_EN to round the quotient to nearest (saturating) instead of truncating.
module shared_divider_arbiter #(
    parameter int WIDTH = 16,
    parameter int N_CH  = 2,
    parameter int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    shared_divider_arbiter_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [ID_W-1:0]  ptr_reg;
    logic [ID_W-1:0]  grant_id_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] part_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             div_zero_reg;
    logic             busy_reg;
    logic [N_CH-1:0]  ack_reg;

    logic [WIDTH-1:0] dividend_ch [N_CH];
    logic [WIDTH-1:0] divisor_ch  [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_split
            assign dividend_ch[gi] = bus.dividend_bus[gi*WIDTH +: WIDTH];
            assign divisor_ch[gi]  = bus.divisor_bus[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // First requester at or after the pointer; scanning from the far end lets the
    // nearest one overwrite the selection.
    logic            any_req;
    logic [ID_W-1:0] grant_sel;
    int              rr_idx;

    always_comb begin
        any_req   = 1'b0;
        grant_sel = '0;
        rr_idx    = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            rr_idx = int'(ptr_reg) + i;
            if (rr_idx >= N_CH)
                rr_idx = rr_idx - N_CH;
            if (bus.req[rr_idx]) begin
                any_req   = 1'b1;
                grant_sel = ID_W'(rr_idx);
            end
        end
    end

    // Restoring step: the trial value carries one extra bit so the compare never overflows.
    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;
    logic             sub_ok;
    logic [WIDTH-1:0] part_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] q_final;
    logic             round_up;

    always_comb begin
        trial     = {part_reg, dvd_reg[WIDTH-1]};
        diff      = {1'b0, trial} - {2'b00, divisor_reg};
        sub_ok    = ~diff[WIDTH+1];
        part_next = sub_ok ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next  = {dvd_reg[WIDTH-2:0], sub_ok};
        round_up  = ({part_next, 1'b0} >= {1'b0, divisor_reg});
`ifdef DIV_ROUND_EN
        q_final   = (round_up && !(&quo_next)) ? quo_next + 1'b1 : quo_next;
`else
        q_final   = quo_next;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            grant_id_reg  <= '0;
            cnt_reg       <= '0;
            dvd_reg       <= '0;
            divisor_reg   <= '0;
            part_reg      <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            ack_reg       <= '0;
        end else begin
            ack_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_id_reg <= grant_sel;
                        ptr_reg      <= (grant_sel == ID_W'(N_CH - 1)) ? '0 : grant_sel + 1'b1;
                        busy_reg     <= 1'b1;
                        dvd_reg      <= dividend_ch[grant_sel];
                        divisor_reg  <= divisor_ch[grant_sel];
                        part_reg     <= '0;
                        cnt_reg      <= CNT_W'(WIDTH - 1);
                        if (divisor_ch[grant_sel] == '0) begin
                            quotient_reg  <= '1;
                            remainder_reg <= dividend_ch[grant_sel];
                            div_zero_reg  <= 1'b1;
                            ack_reg       <= N_CH'(1) << grant_sel;
                            state_reg     <= DONE;
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    part_reg <= part_next;
                    dvd_reg  <= quo_next;
                    cnt_reg  <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        quotient_reg  <= q_final;
                        remainder_reg <= part_next;
                        div_zero_reg  <= 1'b0;
                        ack_reg       <= N_CH'(1) << grant_id_reg;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ack       = ack_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.div_zero  = div_zero_reg;
    assign bus.busy      = busy_reg;
    assign bus.grant_id  = grant_id_reg;
endmodule

// File: tb/tb_shared_divider_arbiter.sv
// Directed bench for shared_divider_arbiter: vector table of single-channel divisions,
// then round-robin contention and reset-abort sequences.
module tb_shared_divider_arbiter;
    localparam int WIDTH = 16;
    localparam int N_CH  = 2;
`ifdef DIV_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    shared_divider_arbiter_if #(.WIDTH(WIDTH), .N_CH(N_CH)) dif ();

    shared_divider_arbiter #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dif)
    );

    typedef struct {
        int          ch;
        logic [15:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q_trunc;
        logic [15:0] q_round;
        logic [15:0] rem;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[9];
    int   n_checks = 0;
    int   n_err    = 0;

    int   exp_q_ch[N_CH];
    int   exp_r_ch[N_CH];
    int   g_ids[8];
    int   g_cyc[8];
    int   n_g;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ops(input int ch, input logic [15:0] dvd, input logic [15:0] dvs);
        dif.dividend_bus[ch*WIDTH +: WIDTH] = dvd;
        dif.divisor_bus[ch*WIDTH +: WIDTH]  = dvs;
    endtask

    // Serves contending channels, dropping a channel's req when its ack is seen and
    // optionally re-raising it one cycle later; records each grant and its cycle.
    task automatic run_arb(input bit reraise, input int n_grants, input int max_cyc);
        logic [N_CH-1:0] pend;
        bit prev_busy;
        bit prev_ack;
        int cyc;
        pend      = '0;
        prev_busy = dif.busy;
        prev_ack  = 1'b0;
        cyc       = 0;
        n_g       = 0;
        while (cyc < max_cyc) begin
            tick();
            cyc++;
            for (int k = 0; k < N_CH; k++) begin
                if (pend[k] && reraise && n_g < n_grants)
                    dif.req[k] = 1'b1;
                pend[k] = 1'b0;
            end
            if (dif.busy && !prev_busy && n_g < 8) begin
                g_ids[n_g] = int'(dif.grant_id);
                g_cyc[n_g] = cyc;
                n_g++;
                if (n_g >= n_grants)
                    dif.req = '0;
            end
            if (dif.ack != '0) begin
                check("arb_ack_one_cycle", int'(prev_ack), 0);
                for (int k = 0; k < N_CH; k++) begin
                    if (dif.ack[k]) begin
                        check("arb_quotient", int'(dif.quotient), exp_q_ch[k]);
                        check("arb_remainder", int'(dif.remainder), exp_r_ch[k]);
                        $display("arb ack ch%0d cyc=%0d q=%0h r=%0h", k, cyc, dif.quotient, dif.remainder);
                        dif.req[k] = 1'b0;
                        pend[k]    = 1'b1;
                    end
                end
            end
            prev_ack  = (dif.ack != '0);
            prev_busy = dif.busy;
            if (n_g >= n_grants && !dif.busy && dif.req == '0)
                break;
        end
        check("arb_grant_count", n_g, n_grants);
        check("arb_finished", int'(dif.busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dif.req = '0;
        #1;
        check("rst_quotient", int'(dif.quotient), 0);
        check("rst_remainder", int'(dif.remainder), 0);
        check("rst_status", int'({dif.ack, dif.busy, dif.div_zero, dif.grant_id}), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int   cnt;
        int   n;
        vec_t v;
        logic [15:0] exp_q;

        vecs[0] = '{0, 16'd100,   16'd7,      16'd14,     16'd14,     16'd2,      1'b0, 17};
        vecs[1] = '{1, 16'd100,   16'd8,      16'd12,     16'd13,     16'd4,      1'b0, 17};
        vecs[2] = '{0, 16'h1234,  16'h0000,   16'hFFFF,   16'hFFFF,   16'h1234,   1'b1, 1};
        vecs[3] = '{1, 16'hFFFF,  16'h0001,   16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 17};
        vecs[4] = '{0, 16'd5,     16'hFFFF,   16'd0,      16'd0,      16'd5,      1'b0, 17};
        vecs[5] = '{1, 16'hFFFE,  16'hFFFF,   16'd0,      16'd1,      16'hFFFE,   1'b0, 17};
        vecs[6] = '{0, 16'd0,     16'd3,      16'd0,      16'd0,      16'd0,      1'b0, 17};
        vecs[7] = '{1, 16'd1000,  16'd33,     16'd30,     16'd30,     16'd10,     1'b0, 17};
        vecs[8] = '{0, 16'd7,     16'd2,      16'd3,      16'd4,      16'd1,      1'b0, 17};

        dif.req          = '0;
        dif.dividend_bus = '0;
        dif.divisor_bus  = '0;
        do_reset();

        // Single-channel vectors; req is dropped right after the grant and operands
        // are scrambled, so the result must come from the grant-edge sample.
        for (int i = 0; i < 9; i++) begin
            v     = vecs[i];
            exp_q = ROUND_EN ? v.q_round : v.q_trunc;
            set_ops(v.ch, v.dvd, v.dvs);
            dif.req[v.ch] = 1'b1;
            cnt = 0;
            while (!dif.busy && cnt < 10) begin
                tick();
                cnt++;
            end
            check("vec_grant_seen", int'(dif.busy), 1);
            check("vec_grant_id", int'(dif.grant_id), v.ch);
            dif.req          = '0;
            dif.dividend_bus = $urandom;
            dif.divisor_bus  = $urandom;
            n = 0;
            while (!dif.ack[v.ch] && n < 40) begin
                tick();
                n++;
            end
            check("vec_latency", n + 1, v.lat);
            check("vec_quotient", int'(dif.quotient), int'(exp_q));
            check("vec_remainder", int'(dif.remainder), int'(v.rem));
            check("vec_div_zero", int'(dif.div_zero), int'(v.dz));
            check("vec_ack_onehot", int'(dif.ack), 1 << v.ch);
            $display("op %0d ch%0d %0h/%0h -> q=%0h r=%0h dz=%0b lat=%0d",
                     i, v.ch, v.dvd, v.dvs, dif.quotient, dif.remainder, dif.div_zero, n + 1);
            tick();
            check("vec_ack_cleared", int'(dif.ack), 0);
            check("vec_busy_cleared", int'(dif.busy), 0);
        end

        // Round-robin: both channels request continuously from reset.
        do_reset();
        set_ops(0, 16'd100, 16'd7);
        set_ops(1, 16'd100, 16'd8);
        exp_q_ch[0] = 14;
        exp_r_ch[0] = 2;
        exp_q_ch[1] = ROUND_EN ? 13 : 12;
        exp_r_ch[1] = 4;
        dif.req = 2'b11;
        run_arb(1'b1, 4, 150);
        for (int i = 0; i < 4; i++)
            check("rr_order", g_ids[i], i % 2);
        for (int i = 1; i < 4; i++)
            check("rr_gap", g_cyc[i] - g_cyc[i-1], 18);

        // Reset in the middle of a run on ch0, which would leave the pointer at 1.
        set_ops(0, 16'd100, 16'd7);
        dif.req[0] = 1'b1;
        cnt = 0;
        while (!dif.busy && cnt < 10) begin
            tick();
            cnt++;
        end
        check("abort_grant_seen", int'(dif.busy), 1);
        dif.req = '0;
        repeat (8) tick();
        do_reset();
        n = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (dif.ack != '0)
                n++;
        end
        check("abort_no_ack", n, 0);
        $display("abort: reset applied mid-run, ack cycles afterwards=%0d", n);

        set_ops(0, 16'd9, 16'd4);
        set_ops(1, 16'd500, 16'd7);
        exp_q_ch[0] = 2;
        exp_r_ch[0] = 1;
        exp_q_ch[1] = 71;
        exp_r_ch[1] = 3;
        dif.req = 2'b11;
        run_arb(1'b0, 2, 80);
        check("abort_ptr_first", g_ids[0], 0);
        check("abort_ptr_second", g_ids[1], 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
